// File: rtl/fifo_burst_reader_if.sv
// FIFO read port and valid/ready stream bundle for fifo_burst_reader.
// master = the burst reader, slave = FIFO plus downstream consumer.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty_i;
    logic                  fifo_rd_en_o;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_last_o;

    modport master (
        input  fifo_empty_i, fifo_data_i, m_ready_i,
        output fifo_rd_en_o, m_valid_o, m_data_o, m_last_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_i, m_ready_i,
        input  fifo_rd_en_o, m_valid_o, m_data_o, m_last_o
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read master for a 1-cycle-latency BRAM FIFO: pulls len_i words and
// streams them out through a 2-entry skid buffer, tagging the last word.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    fifo_burst_reader_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  out_cnt;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  done_q;
    logic                  rd_en;
    logic                  pop;

    assign pop = (occ != 2'd0) && bus.m_ready_i;

    // A read may only issue if its word will have a free slot when it lands;
    // the pop term is added on the right to keep the sum unsigned.
    assign rd_en = (state == RUN) && !bus.fifo_empty_i && (issue_cnt != '0) &&
                   (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            issue_cnt <= '0;
            out_cnt   <= '0;
            skid0     <= '0;
            skid1     <= '0;
            occ       <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= rd_en;

            if (rd_en) begin
                issue_cnt <= issue_cnt - LEN_ONE;
            end
            if (pop) begin
                out_cnt <= out_cnt - LEN_ONE;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            issue_cnt <= len_i;
                            out_cnt   <= len_i;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_en && (issue_cnt == LEN_ONE)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && (out_cnt == LEN_ONE)) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // skid0 is always the head; a capture lands behind whatever survives the pop
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid0 <= bus.fifo_data_i;
                    end else begin
                        skid1 <= bus.fifo_data_i;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= bus.fifo_data_i;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= bus.fifo_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o           = (state != IDLE);
    assign done_o           = done_q;
    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = (occ != 2'd0);
    assign bus.m_data_o     = skid0;
    assign bus.m_last_o     = (occ != 2'd0) && (out_cnt == LEN_ONE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, word-order scoreboard and
// directed plus randomized bursts.
module tb_fifo_burst_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .len_i   (len),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus)
    );

    // Synchronous FIFO with registered read data; reset flushes it.
    logic [DW-1:0] mem [0:1023];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;

    assign bus.fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr          <= wr_ptr;
            bus.fifo_data_i <= '0;
        end else if (bus.fifo_rd_en_o && (wr_ptr != rd_ptr)) begin
            bus.fifo_data_i <= mem[rd_ptr[9:0]];
            rd_ptr          <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] wq[$];
    bit  m_busy     = 1'b0;
    bit  m_done     = 1'b0;
    int  remaining  = 0;
    int  burst_len  = 0;
    int  rd_burst   = 0;
    bit  prev_stall = 1'b0;

    int            hs_cyc[$];
    logic [DW-1:0] hs_data[$];
    bit            hs_last[$];
    int            rd_cyc[$];
    int            done_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        bit hs;
        hs = bus.m_valid_o && bus.m_ready_i;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (bus.fifo_rd_en_o) begin
            chk("rd_while_empty", bus.fifo_empty_i, 0);
            rd_burst++;
            chk("over_read", rd_burst > burst_len, 0);
            rd_cyc.push_back(cyc);
        end
        if (!bus.m_valid_o) chk("last_without_valid", bus.m_last_o, 0);
        if (prev_stall) chk("valid_dropped_under_stall", bus.m_valid_o, 1);
        if (bus.m_valid_o) begin
            if (remaining == 0 || wq.size() == 0) begin
                chk("valid_unexpected", bus.m_valid_o, 0);
            end else begin
                chk("data", bus.m_data_o, wq[0]);
                chk("last", bus.m_last_o, remaining == 1);
            end
            if (hs) begin
                hs_cyc.push_back(cyc);
                hs_data.push_back(bus.m_data_o);
                hs_last.push_back(bus.m_last_o);
            end
        end
        prev_stall = bus.m_valid_o && !bus.m_ready_i;
        if (done) done_cyc.push_back(cyc);
    endtask

    task automatic model_update();
        bit hs;
        bit nb;
        bit nd;
        hs = bus.m_valid_o && bus.m_ready_i;
        if (rst) begin
            m_busy = 0; m_done = 0; remaining = 0; burst_len = 0; rd_burst = 0;
            prev_stall = 0;
            wq.delete();
            return;
        end
        nb = m_busy;
        nd = 0;
        if (hs && remaining > 0 && wq.size() > 0) begin
            void'(wq.pop_front());
            remaining--;
            if (remaining == 0) begin
                nb = 0;
                nd = 1;
            end
        end
        if (!m_busy && start) begin
            if (len == '0) begin
                nd = 1;
            end else begin
                nb        = 1;
                remaining = int'(len);
                burst_len = int'(len);
                rd_burst  = 0;
            end
        end
        m_busy = nb;
        m_done = nd;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        model_update();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 1;
        wq.push_back(d);
    endtask

    task automatic clear_logs();
        hs_cyc.delete(); hs_data.delete(); hs_last.delete();
        rd_cyc.delete(); done_cyc.delete();
    endtask

    task automatic start_burst(input int n);
        len   = n[LW-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int i;
        n0 = done_cyc.size();
        i  = 0;
        while (done_cyc.size() == n0 && i < budget) begin
            step();
            i++;
        end
        chk("done_within_budget", done_cyc.size() > n0, 1);
    endtask

    initial begin
        int k;
        int i;
        int n;
        int written;
        logic [DW-1:0] exp3 [3];

        rst = 1'b1; start = 1'b0; len = '0; bus.m_ready_i = 1'b0;
        @(posedge clk); #1; cyc = 1;
        repeat (2) step();
        chk("rst_valid", bus.m_valid_o, 0);
        chk("rst_rd_en", bus.fifo_rd_en_o, 0);
        chk("rst_last", bus.m_last_o, 0);
        chk("rst_data", bus.m_data_o, 0);
        rst = 1'b0;
        step();

        // Basic three-word burst at full rate.
        exp3[0] = 32'hAAAAAAAA; exp3[1] = 32'hBBBBBBBB; exp3[2] = 32'hCCCCCCCC;
        for (int j = 0; j < 3; j++) write_word(exp3[j]);
        clear_logs();
        bus.m_ready_i = 1'b1;
        k = cyc;
        start_burst(3);
        wait_done(50);
        chk("t1_rd_count", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3) begin
            chk("t1_rd_first", rd_cyc[0], k + 1);
            chk("t1_rd_last", rd_cyc[2], k + 3);
        end
        chk("t1_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("t1_hs_cycle", hs_cyc[j], k + 3 + j);
                chk("t1_hs_data", hs_data[j], exp3[j]);
                chk("t1_hs_last", hs_last[j], j == 2);
            end
        end
        chk("t1_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t1_done_cycle", done_cyc[0], k + 6);
        chk("t1_busy_after", busy, 0);

        // Backpressure: consumer stalls from the first valid word.
        for (int j = 0; j < 3; j++) write_word(exp3[j]);
        clear_logs();
        bus.m_ready_i = 1'b0;
        k = cyc;
        start_burst(3);
        i = 0;
        while (!bus.m_valid_o && i < 20) begin step(); i++; end
        chk("t2_first_valid_latency", cyc - k, 3);
        repeat (5) begin
            chk("t2_held_data", bus.m_data_o, 32'hAAAAAAAA);
            step();
        end
        chk("t2_reads_before_stall", rd_cyc.size(), 2);
        bus.m_ready_i = 1'b1;
        wait_done(50);
        chk("t2_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            for (int j = 0; j < 3; j++) chk("t2_hs_data", hs_data[j], exp3[j]);
        end

        // FIFO runs dry mid-burst.
        write_word(32'h11111111); write_word(32'h22222222);
        clear_logs();
        start_burst(4);
        repeat (6) step();
        write_word(32'h33333333);
        step();
        write_word(32'h44444444);
        wait_done(50);
        chk("t3_hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            chk("t3_data2", hs_data[2], 32'h33333333);
            chk("t3_data3", hs_data[3], 32'h44444444);
            chk("t3_last3", hs_last[3], 1);
            if (done_cyc.size() == 1) chk("t3_done_cycle", done_cyc[0], hs_cyc[3] + 1);
        end

        // Zero-length request.
        clear_logs();
        k = cyc;
        start_burst(0);
        repeat (3) step();
        chk("t4_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk("t4_done_cycle", done_cyc[0], k + 1);
        chk("t4_no_reads", rd_cyc.size(), 0);
        chk("t4_no_words", hs_cyc.size(), 0);

        // Reset after the first handshake, then a single-word burst.
        for (int j = 0; j < 3; j++) write_word(exp3[j]);
        clear_logs();
        start_burst(3);
        i = 0;
        while (hs_cyc.size() == 0 && i < 20) begin step(); i++; end
        chk("t5_first_hs_seen", hs_cyc.size(), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", bus.m_valid_o, 0);
        chk("t5_rd_en", bus.fifo_rd_en_o, 0);
        chk("t5_last", bus.m_last_o, 0);
        chk("t5_data", bus.m_data_o, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        repeat (4) step();
        chk("t5_no_done", done_cyc.size(), 0);
        clear_logs();
        write_word(32'h5A5A5A5A);
        start_burst(1);
        wait_done(50);
        chk("t5_one_word", hs_cyc.size(), 1);
        if (hs_cyc.size() == 1) begin
            chk("t5_word_data", hs_data[0], 32'h5A5A5A5A);
            chk("t5_word_last", hs_last[0], 1);
        end

        // Restart attempt while busy is ignored.
        for (int j = 0; j < 3; j++) write_word(exp3[j]);
        clear_logs();
        start_burst(3);
        step();
        len = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(50);
        repeat (3) step();
        chk("t6_hs_count", hs_cyc.size(), 3);
        chk("t6_rd_count", rd_cyc.size(), 3);

        // Randomized bursts: random lengths, FIFO fill timing and ready.
        for (int b = 0; b < 25; b++) begin
            n = $urandom_range(0, 24);
            written = $urandom_range(0, n);
            for (int j = 0; j < written; j++) write_word($urandom);
            bus.m_ready_i = ($urandom_range(0, 3) != 0);
            start_burst(n);
            i = 0;
            while (done_cyc.size() == 0 && i < 2000) begin
                bus.m_ready_i = ($urandom_range(0, 3) != 0);
                if (written < n && $urandom_range(0, 2) == 0) begin
                    write_word($urandom);
                    written++;
                end
                if (m_busy && $urandom_range(0, 15) == 0) begin
                    start = 1'b1;
                    len   = LW'($urandom_range(0, 255));
                end else begin
                    start = 1'b0;
                end
                step();
                i++;
            end
            start = 1'b0;
            chk("rnd_done_within_budget", done_cyc.size() > 0, 1);
            clear_logs();
        end

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
